// File: rtl/ring_fifo_pkg.sv
// Shared types and helpers for the ring FIFO: push policy when full, and the
// per-cycle operation decode used by the controller.
package ring_fifo_pkg;

    typedef enum logic {
        FIFO_DROP      = 1'b0,
        FIFO_OVERWRITE = 1'b1
    } fifo_mode_e;

    // One decoded operation per clock; it selects the pointer/count/flag updates.
    typedef enum logic [2:0] {
        OpNone,
        OpPush,
        OpPop,
        OpBoth,
        OpOverwrite,
        OpDrop,
        OpUflow,
        OpPushUflow
    } fifo_op_e;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ring_fifo_mem.sv
// Ring FIFO storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module ring_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ring_fifo.sv
// Single-clock ring FIFO with first-word-fall-through output, threshold flags,
// selectable drop/overwrite policy on full, and registered overflow/underflow pulses.
module ring_fifo
    import ring_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2,
    parameter fifo_mode_e  MODE     = FIFO_DROP
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         dataIn,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dataOut,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LP_AF    = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] LP_AE    = (AW + 1)'(AE_LEVEL);

    generate
        if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
            $error("ring_fifo: DEPTH must be a power of two >= 2");
        end
        if (AF_LEVEL > DEPTH) begin : g_bad_af
            $error("ring_fifo: AF_LEVEL must not exceed DEPTH");
        end
        if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
            $error("ring_fifo: AE_LEVEL must be below AF_LEVEL");
        end
    endgenerate

    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    fifo_op_e         w_op;
    logic             w_wr;
    logic             w_rd;
    logic             w_inc;
    logic             w_dec;
    logic             w_ovf;
    logic             w_udf;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_DEPTH);

    // Pop on empty takes precedence in the decode so a paired push still lands.
    always_comb begin
        w_op = OpNone;
        if (pop && w_empty) begin
            w_op = push ? OpPushUflow : OpUflow;
        end else if (push && pop) begin
            w_op = OpBoth;
        end else if (pop) begin
            w_op = OpPop;
        end else if (push && !w_full) begin
            w_op = OpPush;
        end else if (push) begin
            w_op = (MODE == FIFO_OVERWRITE) ? OpOverwrite : OpDrop;
        end
    end

    always_comb begin
        w_wr  = 1'b0;
        w_rd  = 1'b0;
        w_inc = 1'b0;
        w_dec = 1'b0;
        w_ovf = 1'b0;
        w_udf = 1'b0;
        unique case (w_op)
            OpPush:      begin w_wr = 1'b1; w_inc = 1'b1; end
            OpPop:       begin w_rd = 1'b1; w_dec = 1'b1; end
            OpBoth:      begin w_wr = 1'b1; w_rd  = 1'b1; end
            OpOverwrite: begin w_wr = 1'b1; w_rd  = 1'b1; w_ovf = 1'b1; end
            OpDrop:      begin w_ovf = 1'b1; end
            OpUflow:     begin w_udf = 1'b1; end
            OpPushUflow: begin w_wr = 1'b1; w_inc = 1'b1; w_udf = 1'b1; end
            default:     begin end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_head <= r_head + AW'(1);
            end
            if (w_rd) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_inc) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_dec) begin
                r_count <= r_count - (AW + 1)'(1);
            end
            r_overflow  <= w_ovf;
            r_underflow <= w_udf;
        end
    end

    ring_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clock),
        .i_we    (w_wr && !reset),
        .i_waddr (r_head),
        .i_wdata (dataIn),
        .i_raddr (r_tail),
        .o_rdata (w_rdata)
    );

    assign dataOut      = w_empty ? '0 : w_rdata;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= LP_AF);
    assign almost_empty = (r_count <= LP_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_ring_fifo.sv
// Bench for ring_fifo: three instances (16x8 drop, 16x8 overwrite, 4x4 drop) share
// one stimulus stream and are checked every cycle against a list-based model.
module tb_ring_fifo;
    import ring_fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] din;

    logic [7:0] d0_dout, d1_dout;
    logic [3:0] d2_dout;
    logic [4:0] d0_cnt, d1_cnt;
    logic [2:0] d2_cnt;
    logic d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
    logic d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;
    logic d2_full, d2_empty, d2_af, d2_ae, d2_ovf, d2_udf;

    ring_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2), .MODE(FIFO_DROP)) u_drop (
        .clock(clk), .reset(rst), .dataIn(din), .push(push), .pop(pop), .dataOut(d0_dout),
        .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
        .count(d0_cnt), .overflow(d0_ovf), .underflow(d0_udf)
    );

    ring_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2), .MODE(FIFO_OVERWRITE)) u_ovw (
        .clock(clk), .reset(rst), .dataIn(din), .push(push), .pop(pop), .dataOut(d1_dout),
        .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
        .count(d1_cnt), .overflow(d1_ovf), .underflow(d1_udf)
    );

    ring_fifo #(.WIDTH(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .MODE(FIFO_DROP)) u_small (
        .clock(clk), .reset(rst), .dataIn(din[3:0]), .push(push), .pop(pop), .dataOut(d2_dout),
        .full(d2_full), .empty(d2_empty), .almost_full(d2_af), .almost_empty(d2_ae),
        .count(d2_cnt), .overflow(d2_ovf), .underflow(d2_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each FIFO is an ordered list, element 0 is the oldest word.
    int unsigned c_depth [3] = '{16, 16, 4};
    int unsigned c_af    [3] = '{12, 12, 3};
    int unsigned c_ae    [3] = '{2, 2, 1};
    bit          c_ovw   [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0]  c_mask  [3] = '{8'hFF, 8'hFF, 8'h0F};

    logic [7:0]  m_list [3][16];
    int unsigned m_cnt  [3];
    bit          m_ovf  [3];
    bit          m_udf  [3];

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s u%0d @%0t: got 0x%0h, required 0x%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic m_drop_oldest(input int k);
        for (int i = 0; i < 15; i++) m_list[k][i] = m_list[k][i+1];
        m_cnt[k]--;
    endtask

    task automatic m_append(input int k, input logic [7:0] d);
        m_list[k][m_cnt[k]] = d & c_mask[k];
        m_cnt[k]++;
    endtask

    task automatic model_step(input int k, input bit r, input bit p, input bit o,
                              input logic [7:0] d);
        m_ovf[k] = 1'b0;
        m_udf[k] = 1'b0;
        if (r) begin
            m_cnt[k] = 0;
        end else if (o && m_cnt[k] == 0) begin
            m_udf[k] = 1'b1;
            if (p) m_append(k, d);
        end else if (p && o) begin
            m_drop_oldest(k);
            m_append(k, d);
        end else if (o) begin
            m_drop_oldest(k);
        end else if (p) begin
            if (m_cnt[k] < c_depth[k]) begin
                m_append(k, d);
            end else begin
                m_ovf[k] = 1'b1;
                if (c_ovw[k]) begin
                    m_drop_oldest(k);
                    m_append(k, d);
                end
            end
        end
    endtask

    task automatic compare_all();
        int a_cnt, a_dout, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
        int e_dout;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    a_cnt = int'(d0_cnt); a_dout = int'(d0_dout); a_full = int'(d0_full);
                    a_empty = int'(d0_empty); a_af = int'(d0_af); a_ae = int'(d0_ae);
                    a_ovf = int'(d0_ovf); a_udf = int'(d0_udf);
                end
                1: begin
                    a_cnt = int'(d1_cnt); a_dout = int'(d1_dout); a_full = int'(d1_full);
                    a_empty = int'(d1_empty); a_af = int'(d1_af); a_ae = int'(d1_ae);
                    a_ovf = int'(d1_ovf); a_udf = int'(d1_udf);
                end
                default: begin
                    a_cnt = int'(d2_cnt); a_dout = int'(d2_dout); a_full = int'(d2_full);
                    a_empty = int'(d2_empty); a_af = int'(d2_af); a_ae = int'(d2_ae);
                    a_ovf = int'(d2_ovf); a_udf = int'(d2_udf);
                end
            endcase
            e_dout = (m_cnt[k] == 0) ? 0 : int'(m_list[k][0]);
            chk("count", k, a_cnt, int'(m_cnt[k]));
            chk("dataOut", k, a_dout, e_dout);
            chk("full", k, a_full, int'(m_cnt[k] == c_depth[k]));
            chk("empty", k, a_empty, int'(m_cnt[k] == 0));
            chk("almost_full", k, a_af, int'(m_cnt[k] >= c_af[k]));
            chk("almost_empty", k, a_ae, int'(m_cnt[k] <= c_ae[k]));
            chk("overflow", k, a_ovf, int'(m_ovf[k]));
            chk("underflow", k, a_udf, int'(m_udf[k]));
        end
    endtask

    // Inputs change at the falling edge; DUT and model both consume them at the
    // next rising edge; outputs are compared at the following falling edge.
    task automatic cycle(input bit r, input bit p, input bit o, input logic [7:0] d);
        rst  = r;
        push = p;
        pop  = o;
        din  = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, p, o, d);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
        end

        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("lit_reset_empty", 0, int'(d0_empty), 1);
        chk("lit_reset_count", 0, int'(d0_cnt), 0);
        chk("lit_reset_dout", 0, int'(d0_dout), 0);
        chk("lit_reset_ae", 0, int'(d0_ae), 1);
        chk("lit_reset_af", 0, int'(d0_af), 0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'(i));
            chk("lit_fill_count", 0, int'(d0_cnt), i);
            chk("lit_fill_af", 0, int'(d0_af), int'(i >= 12));
            chk("lit_fill_dout", 0, int'(d0_dout), 1);
        end
        chk("lit_full", 0, int'(d0_full), 1);
        chk("lit_small_count", 2, int'(d2_cnt), 4);
        chk("lit_small_full", 2, int'(d2_full), 1);

        // Push onto a full buffer in both policies.
        cycle(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("lit_drop_ovf", 0, int'(d0_ovf), 1);
        chk("lit_drop_head", 0, int'(d0_dout), 8'h01);
        chk("lit_ovw_ovf", 1, int'(d1_ovf), 1);
        chk("lit_ovw_head", 1, int'(d1_dout), 8'h02);
        chk("lit_ovw_count", 1, int'(d1_cnt), 16);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("lit_ovf_pulse_end", 0, int'(d0_ovf), 0);

        // Drain, checking order.
        for (int i = 0; i < 16; i++) begin
            chk("lit_drain_drop", 0, int'(d0_dout), i + 1);
            chk("lit_drain_ovw", 1, int'(d1_dout), (i == 15) ? 8'hAA : i + 2);
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
        end
        chk("lit_drained_empty", 0, int'(d0_empty), 1);
        chk("lit_drained_dout", 0, int'(d0_dout), 0);

        // Pointer wrap: two rounds of 10 in / 10 out.
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h20 + 8'h20 * rnd + i));
            for (int i = 0; i < 10; i++) begin
                chk("lit_wrap_dout", 0, int'(d0_dout), 8'h20 + 8'h20 * rnd + i);
                cycle(1'b0, 1'b0, 1'b1, 8'h00);
            end
        end
        chk("lit_wrap_count", 0, int'(d0_cnt), 0);

        // Simultaneous push+pop at count 5, then on an empty buffer.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 8'(8'h70 + i));
        chk("lit_simul_count", 0, int'(d0_cnt), 5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h5C);
        chk("lit_empty_pp_count", 0, int'(d0_cnt), 1);
        chk("lit_empty_pp_udf", 0, int'(d0_udf), 1);
        chk("lit_empty_pp_dout", 0, int'(d0_dout), 8'h5C);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset in the middle of traffic.
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
        cycle(1'b1, 1'b1, 1'b0, 8'h99);
        chk("lit_mid_rst_count", 0, int'(d0_cnt), 0);
        chk("lit_mid_rst_empty", 0, int'(d0_empty), 1);
        chk("lit_mid_rst_dout", 0, int'(d0_dout), 0);
        chk("lit_mid_rst_af", 0, int'(d0_af), 0);
        chk("lit_mid_rst_ovf", 0, int'(d0_ovf), 0);

        // Randomized traffic alternating fill-heavy and drain-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            bit fill_phase;
            bit r, p, o;
            fill_phase = ((i / 300) % 2) == 0;
            r = ($urandom_range(0, 199) == 0);
            p = ($urandom_range(0, 99) < (fill_phase ? 75 : 30));
            o = ($urandom_range(0, 99) < (fill_phase ? 30 : 75));
            cycle(r, p, o, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_fifo.md
RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AF_LEVEL, default 12, almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have parameter MODE, default FIFO_DROP, full-push policy: FIFO_DROP or FIFO_OVERWRITE.
REQ-006 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port dataIn, input, WIDTH, push data.
REQ-009 SHALL have port push, input, 1, push request.
REQ-010 SHALL have port pop, input, 1, pop request.
REQ-011 SHALL have port dataOut, output, WIDTH, head-of-queue word, first-word-fall-through.
REQ-012 SHALL have port full, output, 1, count == DEPTH.
REQ-013 SHALL have port empty, output, 1, count == 0.
REQ-014 SHALL have port almost_full, output, 1, threshold flag.
REQ-015 SHALL have port almost_empty, output, 1, threshold flag.
REQ-016 SHALL have port count, output, AW+1 (AW = log2 DEPTH), current occupancy 0..DEPTH.
REQ-017 SHALL have port overflow, output, 1, one-cycle pulse on a push that hits a full buffer.
REQ-018 SHALL have port underflow, output, 1, one-cycle pulse on a pop from an empty buffer.

Function
REQ-019 SHALL keep head (write) and tail (read) pointers, each AW bits; both wrap DEPTH-1 -> 0 by natural modulo.
REQ-020 SHALL accept pop when !empty: tail+1, count-1.
REQ-021 SHALL accept push when !full: mem[head] <= dataIn, head+1, count+1.
REQ-022 SHALL, on simultaneous push and pop with 0 < count < DEPTH, perform both; count unchanged.
REQ-023 SHALL, on push and pop while empty, perform push only; raise underflow.
REQ-024 SHALL, on push and pop while full, perform both in either MODE; count stays DEPTH; no overflow.
REQ-025 SHALL, on push alone while full and MODE=FIFO_DROP, discard dataIn with no state change and raise overflow.
REQ-026 SHALL, on push alone while full and MODE=FIFO_OVERWRITE, write mem[head], advance head and tail, keep count = DEPTH and raise overflow.
REQ-027 SHALL, on pop alone while empty, make no state change and raise underflow.
REQ-028 SHALL drive dataOut = mem[tail] combinationally from registered state; a word pushed at edge N appears on dataOut after edge N when the FIFO was empty (zero-cycle bubble).
REQ-029 SHALL drive dataOut to 0 whenever empty is 1.
REQ-030 SHALL derive full, empty, almost_full and almost_empty combinationally from the registered count.
REQ-031 SHALL register overflow and underflow; each is high for exactly the cycle after the offending edge.

Reset
REQ-032 SHALL, on reset high at a clock edge, set head=0, tail=0, count=0, overflow=0 and underflow=0, giving empty=1, full=0, almost_empty=1, almost_full=0 and dataOut=0.
REQ-033 SHALL give reset priority over push and pop in the same cycle; a mid-operation reset discards all queued entries.
REQ-034 SHALL leave storage contents unreset; they are unobservable because of REQ-029.

Structure
REQ-035 SHALL place typedef enum fifo_mode_e {FIFO_DROP, FIFO_OVERWRITE} in shared package ring_fifo_pkg.
REQ-036 SHALL implement storage as sub-module ring_fifo_mem (DEPTH x WIDTH, one synchronous write port, one asynchronous read port).
REQ-037 SHALL reject, at elaboration, a non-power-of-two DEPTH, AF_LEVEL > DEPTH or AE_LEVEL >= AF_LEVEL.

Verification (defaults unless stated)
REQ-038 SHALL test fill and drain: push 0x01..0x10 -> full=1, count=16, almost_full from the 12th push; 16 pops -> data 0x01..0x10 in order, then empty=1, dataOut=0.
REQ-039 SHALL test wrap: push 10, pop 10, push 10, pop 10 -> data in order across the pointer wrap; count returns to 0.
REQ-040 SHALL test simultaneous events: count=5 with push+pop for 20 cycles -> count stays 5; empty with push+pop -> count=1, underflow pulse.
REQ-041 SHALL test a full push: FIFO_DROP, push 0xAA -> overflow pulse, oldest word unchanged; FIFO_OVERWRITE, push 0xAA -> overflow, dataOut = second-oldest word, last pop returns 0xAA.
REQ-042 SHALL test mid-operation reset: count=7 with reset+push -> next cycle count=0, empty=1, dataOut=0, flags 0.
REQ-043 SHALL test DEPTH=4, WIDTH=4, AF_LEVEL=3, AE_LEVEL=1 -> all above properties hold scaled.
